// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg
// Shared definitions for the UART transmit peripheral: TX state encoding,
// register offsets within the peripheral window and STATUS bit positions.
// Build option: UART_TX_PARITY_EN adds a PARITY state (even parity bit
// between the data bits and the stop bit).

package uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam logic [31:0] OFF_TXDATA = 32'h0000_0000;
    localparam logic [31:0] OFF_STATUS = 32'h0000_0004;

    localparam int STAT_FULL  = 1;
    localparam int STAT_EMPTY = 2;
    localparam int STAT_BUSY  = 3;

    function automatic logic [31:0] status_word(input logic busy,
                                                input logic empty,
                                                input logic full);
        logic [31:0] w;
        w             = '0;
        w[STAT_BUSY]  = busy;
        w[STAT_EMPTY] = empty;
        w[STAT_FULL]  = full;
        return w;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Synchronous byte FIFO feeding the UART shifter. The full/empty flags are
// registered and computed from the next occupancy. A push and a pop in the
// same cycle leave the occupancy unchanged.
// Ports:
//   clk, rstn      clock, asynchronous active-low reset (FIFO emptied)
//   push, wdata    write strobe and data (ignored while full)
//   pop            read strobe (ignored while empty); rdata shows the head
//   full, empty    registered occupancy flags
// DEPTH must be a power of two.

module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap explicitly at DEPTH-1 rather than relying on overflow.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            count <= count_next;
            full  <= (count_next == CNT_W'(DEPTH));
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/uart_tx_periph.sv
// uart_tx_periph
// Memory-mapped UART transmitter on a NoC valid/ready slave port.
// Register window at BASE_ADDR:
//   +0x0 TXDATA  (write-only)  byte pushed into the TX FIFO
//   +0x4 STATUS  (read-only)   {28'b0, tx_busy, fifo_empty, fifo_full, 1'b0}
//   other offsets are reserved: writes dropped, reads return 0.
// One response is outstanding at most; a TXDATA write waits while the FIFO
// is full.
// Frame: start(0), 8 data bits LSB first, [even parity], stop(1), each bit
// CLK_DIV clock cycles. Build option UART_TX_PARITY_EN enables the parity bit.
// Ports:
//   clk, rstn                         clock, asynchronous active-low reset
//   req_valid/req_ready               request handshake
//   req_addr, req_wen, req_data       request address, write enable, data
//   resp_valid/resp_ready, resp_data  response handshake and read data
//   uart_tx                           serial output, idle high

module uart_tx_periph
    import uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h1001_0000,
    parameter int          CLK_DIV    = 278,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wen,
    input  logic [31:0] req_data,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        uart_tx
);

    localparam int BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLK_DIV - 1);

    logic [31:0]       offset;
    logic              is_txdata;
    logic              is_status;
    logic              accept;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [7:0]        fifo_rdata;
    logic              tx_busy;
    logic              unused_ok;

    tx_state_t         state;
    tx_state_t         state_next;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BAUD_W-1:0] baud_next;
    logic [2:0]        bit_cnt;
    logic [2:0]        bit_next;
    logic [7:0]        shreg;
    logic [7:0]        shreg_next;
    logic              tx_next;
    logic              baud_done;

    assign unused_ok = ^req_data[31:8];

    assign offset    = req_addr - BASE_ADDR;
    assign is_txdata = (offset == OFF_TXDATA);
    assign is_status = (offset == OFF_STATUS);

    // A pending response blocks new requests; a TXDATA write also waits for
    // FIFO space, judged on the registered full flag.
    assign req_ready = !resp_valid && !(req_wen && is_txdata && fifo_full);
    assign accept    = req_valid && req_ready;
    assign push      = accept && req_wen && is_txdata;
    assign tx_busy   = (state != ST_IDLE);

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .wdata (req_data[7:0]),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            resp_valid <= 1'b0;
            resp_data  <= '0;
        end else if (accept) begin
            resp_valid <= 1'b1;
            resp_data  <= (!req_wen && is_status)
                          ? status_word(tx_busy, fifo_empty, fifo_full)
                          : 32'h0;
        end else if (resp_valid && resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            uart_tx  <= 1'b1;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_cnt  <= bit_next;
            shreg    <= shreg_next;
            uart_tx  <= tx_next;
        end
    end

    // The serial output is registered from the next-state values so the line
    // changes exactly on the cycle a state (or data bit) begins.
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_cnt;
        shreg_next = shreg;
        pop        = 1'b0;
        tx_next    = 1'b1;
        baud_done  = (baud_cnt == '0);

        if (state != ST_IDLE && !baud_done) begin
            baud_next = baud_cnt - 1'b1;
        end

        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shreg_next = fifo_rdata;
                    state_next = ST_START;
                    baud_next  = BAUD_LOAD;
                end
            end
            ST_START: begin
                if (baud_done) begin
                    state_next = ST_DATA;
                    baud_next  = BAUD_LOAD;
                    bit_next   = '0;
                end
            end
            ST_DATA: begin
                if (baud_done) begin
                    baud_next = BAUD_LOAD;
                    if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next = ST_PARITY;
`else
                        state_next = ST_STOP;
`endif
                    end else begin
                        bit_next = bit_cnt + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_done) begin
                    state_next = ST_STOP;
                    baud_next  = BAUD_LOAD;
                end
            end
`endif
            ST_STOP: begin
                if (baud_done) begin
                    // Back-to-back frames: go straight to the next start bit.
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        shreg_next = fifo_rdata;
                        state_next = ST_START;
                        baud_next  = BAUD_LOAD;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                baud_next  = '0;
            end
        endcase

        case (state_next)
            ST_START:  tx_next = 1'b0;
            ST_DATA:   tx_next = shreg_next[bit_next];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_next = ^shreg_next;
`endif
            default:   tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_periph.sv
// tb_uart_tx_periph
// Directed self-checking bench for uart_tx_periph with CLK_DIV=4 and
// FIFO_DEPTH=8. Inputs are driven and outputs sampled 1 time unit after the
// rising clock edge. Honours UART_TX_PARITY_EN (11-bit frames).

module tb_uart_tx_periph;

    localparam logic [31:0] BASE  = 32'h1001_0000;
    localparam int          DIV   = 4;
`ifdef UART_TX_PARITY_EN
    localparam int          FRAME = 11 * DIV;
`else
    localparam int          FRAME = 10 * DIV;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        req_wen = 1'b0;
    logic [31:0] req_data = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic        uart_tx;

    int checks = 0;
    int failures = 0;

    uart_tx_periph #(
        .BASE_ADDR  (BASE),
        .CLK_DIV    (DIV),
        .FIFO_DEPTH (8)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_wen    (req_wen),
        .req_data   (req_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .uart_tx    (uart_tx)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Present one request and hold it until accepted; returns the number of
    // cycles req_ready was low.
    task automatic applyStimulus(input logic wen, input logic [31:0] addr,
                                 input logic [31:0] data, input string tag,
                                 output int waited);
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_data  = data;
        #1;
        waited = 0;
        while (!req_ready && waited < 500) begin
            tick();
            waited++;
        end
        checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        req_wen   = 1'b0;
        req_addr  = '0;
        req_data  = '0;
    endtask

    task automatic takeResponse(input string tag, output logic [31:0] rd);
        int w;
        w = 0;
        while (!resp_valid && w < 50) begin
            tick();
            w++;
        end
        checkOutput({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
        rd = resp_data;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        checkOutput({tag, "_resp_clear"}, 32'(resp_valid), 32'd0);
    endtask

    task automatic regWrite(input logic [31:0] addr, input logic [31:0] data, input string tag);
        int          w;
        logic [31:0] rd;
        applyStimulus(1'b1, addr, data, tag, w);
        takeResponse(tag, rd);
        checkOutput({tag, "_wr_resp_data"}, rd, 32'h0);
    endtask

    task automatic regRead(input logic [31:0] addr, input string tag, output logic [31:0] rd);
        int w;
        applyStimulus(1'b0, addr, 32'h0, tag, w);
        takeResponse(tag, rd);
    endtask

    task automatic checkLine(input string tag, input logic exp, input int n);
        for (int i = 0; i < n; i++) begin
            checkOutput(tag, 32'(uart_tx), 32'(exp));
            tick();
        end
    endtask

    // Checks the rest of a frame; startCycles is how many start-bit samples
    // remain from the current sample point.
    task automatic checkFrame(input string tag, input logic [7:0] b, input int startCycles);
        checkLine({tag, "_start"}, 1'b0, startCycles);
        for (int i = 0; i < 8; i++) begin
            checkLine($sformatf("%s_bit%0d", tag, i), b[i], DIV);
        end
`ifdef UART_TX_PARITY_EN
        checkLine({tag, "_parity"}, ^b, DIV);
`endif
        checkLine({tag, "_stop"}, 1'b1, DIV);
    endtask

    initial begin
        logic [31:0] rd;
        int          waited;

        $display("[TB] start, frame length %0d cycles", FRAME);

        // Reset values while rstn is low.
        #12;
        checkOutput("rst_uart_tx", 32'(uart_tx), 32'd1);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_resp_data", resp_data, 32'h0);
        tick();
        rstn = 1'b1;
        tick();
        checkOutput("post_rst_uart_tx", 32'(uart_tx), 32'd1);

        // STATUS after reset: only fifo_empty set.
        regRead(BASE + 32'h4, "status_reset", rd);
        checkOutput("status_reset_value", rd, 32'h4);

        // Reserved offset: write dropped, read returns zero.
        regWrite(BASE + 32'h8, 32'h55, "rsvd_wr");
        checkLine("rsvd_wr_line_idle", 1'b1, 3);
        regRead(BASE + 32'h4, "rsvd_status", rd);
        checkOutput("rsvd_status_value", rd, 32'h4);
        regRead(BASE + 32'h8, "rsvd_rd", rd);
        checkOutput("rsvd_rd_value", rd, 32'h0);

        // 0x41: start low one cycle after the pop, then 1,0,0,0,0,0,1,0, stop.
        applyStimulus(1'b1, BASE, 32'h41, "tx41", waited);
        checkOutput("tx41_idle_at_accept", 32'(uart_tx), 32'd1);
        takeResponse("tx41", rd);
        checkOutput("tx41_resp_data", rd, 32'h0);
        checkFrame("tx41", 8'h41, DIV);
        checkLine("tx41_idle_after", 1'b1, 4);
        regRead(BASE + 32'h4, "status_after41", rd);
        checkOutput("status_after41_value", rd, 32'h4);

        // STATUS during a frame with one byte queued: busy only.
        regWrite(BASE, 32'hC3, "busyA");
        regWrite(BASE, 32'h3C, "busyB");
        regRead(BASE + 32'h4, "status_busy", rd);
        checkOutput("status_busy_value", rd, 32'h8);
        repeat (2 * FRAME + 10) tick();
        regRead(BASE + 32'h4, "status_drained", rd);
        checkOutput("status_drained_value", rd, 32'h4);

        // Response back-pressure for 5 cycles with another write waiting.
        applyStimulus(1'b0, BASE + 32'h4, 32'h0, "bp", waited);
        req_valid = 1'b1;
        req_wen   = 1'b1;
        req_addr  = BASE;
        req_data  = 32'hEE;
        #1;
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("bp_resp_valid_c%0d", i), 32'(resp_valid), 32'd1);
            checkOutput($sformatf("bp_resp_data_c%0d", i), resp_data, 32'h4);
            checkOutput($sformatf("bp_req_ready_c%0d", i), 32'(req_ready), 32'd0);
            tick();
        end
        req_valid = 1'b0;
        req_wen   = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        takeResponse("bp", rd);
        checkOutput("bp_resp_data_final", rd, 32'h4);
        checkLine("bp_no_stray_frame", 1'b1, 3);
        regRead(BASE + 32'h4, "bp_status", rd);
        checkOutput("bp_status_value", rd, 32'h4);

        // Back-to-back: 0xA5 goes straight to the shifter, the next eight
        // bytes fill the FIFO, and the ninth write stalls until the end of
        // the 0xA5 frame pops the FIFO.
        regWrite(BASE, 32'hA5, "b2b_primer");
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, BASE, 32'(i), $sformatf("b2b_w%0d", i), waited);
            checkOutput($sformatf("b2b_w%0d_nowait", i), 32'(waited), 32'd0);
            takeResponse($sformatf("b2b_w%0d", i), rd);
        end
        regRead(BASE + 32'h4, "b2b_status_full", rd);
        checkOutput("b2b_status_full_value", rd, 32'hA);
        req_valid = 1'b1;
        req_wen   = 1'b1;
        req_addr  = BASE;
        req_data  = 32'h09;
        #1;
        checkOutput("b2b_ninth_stalled", 32'(req_ready), 32'd0);
        // Primer frame start was sampled 18 cycles ago; space appears at the
        // first sample of the next frame's start bit.
        applyStimulus(1'b1, BASE, 32'h09, "b2b_w9", waited);
        checkOutput("b2b_w9_wait_cycles", 32'(waited), 32'(FRAME - 18));
        checkOutput("b2b_frame2_start", 32'(uart_tx), 32'd0);
        takeResponse("b2b_w9", rd);
        checkFrame("b2b_f2", 8'h01, DIV - 2);
        checkFrame("b2b_f3", 8'h02, DIV);
        repeat (7 * FRAME + 10) tick();
        regRead(BASE + 32'h4, "b2b_status_end", rd);
        checkOutput("b2b_status_end_value", rd, 32'h4);

        // Reset in the middle of DATA with a second byte queued.
        regWrite(BASE, 32'h00, "rstmid_a");
        regWrite(BASE, 32'hFF, "rstmid_b");
        repeat (4) tick();
        checkOutput("rstmid_line_low_in_data", 32'(uart_tx), 32'd0);
        rstn = 1'b0;
        #1;
        checkOutput("rstmid_uart_tx", 32'(uart_tx), 32'd1);
        checkOutput("rstmid_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rstmid_req_ready", 32'(req_ready), 32'd1);
        tick();
        tick();
        rstn = 1'b1;
        tick();
        regRead(BASE + 32'h4, "rstmid_status", rd);
        checkOutput("rstmid_status_value", rd, 32'h4);
        checkLine("rstmid_line_idle", 1'b1, FRAME + 10);

        // 0x07: bits 1,1,1,0,0,0,0,0 and even parity 1 when enabled.
        regWrite(BASE, 32'h07, "tx07");
        checkFrame("tx07", 8'h07, DIV);
        checkLine("tx07_idle_after", 1'b1, 4);
        regRead(BASE + 32'h4, "tx07_status", rd);
        checkOutput("tx07_status_value", rd, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_periph.md
UART_TX_PERIPH -- requirements
Module: uart_tx_periph

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h10010000, base of the register window.
REQ-002 SHALL have parameter CLK_DIV, default 278, clk cycles per UART bit (32 MHz / 115200).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, TX byte FIFO entries (power of two, 2 to 64).
REQ-004 SHALL have port clk, input, 1, clock.
REQ-005 SHALL have port rstn, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid, input, 1, request from the NoC slave port.
REQ-007 SHALL have port req_ready, output, 1, request accepted when it is high together with req_valid.
REQ-008 SHALL have port req_addr, input, 32, byte address.
REQ-009 SHALL have port req_wen, input, 1, 1 for write, 0 for read.
REQ-010 SHALL have port req_data, input, 32, write data.
REQ-011 SHALL have port resp_valid, output, 1, response available.
REQ-012 SHALL have port resp_ready, input, 1, response consumed.
REQ-013 SHALL have port resp_data, output, 32, read data; 0 for writes.
REQ-014 SHALL have port uart_tx, output, 1, serial line, idle high.

Function
REQ-015 SHALL decode register offsets req_addr - BASE_ADDR: 0x0 TXDATA (write-only), 0x4 STATUS (read-only), all others reserved.
REQ-016 SHALL, on an accepted TXDATA write, push req_data[7:0] into the FIFO.
REQ-017 SHALL return STATUS reads as {28'b0, tx_busy, fifo_empty, fifo_full, 1'b0} in bits [3:0].
REQ-018 SHALL treat reserved-offset writes as dropped and return 0 for reserved-offset reads, each with a normal response.
REQ-019 SHALL drive req_ready = !resp_valid && !(req_wen && addr==TXDATA && fifo_full), so at most one response is outstanding.
REQ-020 SHALL assert resp_valid the cycle after acceptance and hold it, with resp_data stable, until resp_valid && resp_ready.
REQ-021 SHALL implement the TX state machine IDLE -> START -> DATA -> STOP -> IDLE, with each state lasting CLK_DIV cycles.
REQ-022 SHALL leave IDLE when the FIFO is non-empty: the FIFO pops in that cycle, and uart_tx goes low on the next cycle.
REQ-023 SHALL in DATA send 8 bits LSB first, with the bit counter running 0..7.
REQ-024 SHALL drive uart_tx high in STOP.
REQ-025 SHALL go from STOP directly to START, with no idle gap, when the FIFO is non-empty at the end of STOP.
REQ-026 SHALL use a baud counter that loads CLK_DIV-1 on state entry and advances the state at 0.
REQ-027 SHALL set tx_busy = (state != IDLE).
REQ-028 SHALL, on a simultaneous push and pop, keep the FIFO count unchanged; the full flag used for req_ready is the current registered flag.
REQ-029 SHALL wrap the FIFO pointers modulo FIFO_DEPTH.

Reset
REQ-030 SHALL on reset set: state IDLE, uart_tx 1, req_ready 1, resp_valid 0, resp_data 0, FIFO empty, counters 0.
REQ-031 SHALL, when reset is asserted mid-frame, abort the frame immediately, drive uart_tx high and discard the FIFO contents.

Configuration
REQ-032 SHALL, when UART_TX_PARITY_EN is defined, insert a PARITY state between DATA and STOP that sends even parity (^data) for CLK_DIV cycles, giving an 11-bit frame.
REQ-033 SHALL, when UART_TX_PARITY_EN is undefined, have no PARITY state and use a 10-bit frame.

Structure
REQ-034 SHALL place the state enum, register offsets and STATUS bit positions in package uart_tx_pkg.
REQ-035 SHALL instantiate the FIFO as sub-module uart_tx_fifo (synchronous, registered full/empty flags).

Verification
REQ-036 SHALL cover: write 0x41 to 0x10010000 with CLK_DIV=4 -> uart_tx low for 4 cycles, then bits 1,0,0,0,0,0,1,0 each for 4 cycles, then high for 4 cycles.
REQ-037 SHALL cover: 9 back-to-back TXDATA writes with FIFO_DEPTH=8 -> req_ready low on the 9th until the first pop, and frames sent contiguously.
REQ-038 SHALL cover: STATUS read after reset -> 0x4; STATUS read during a frame with 1 byte queued -> 0x8.
REQ-039 SHALL cover: resp_ready held low for 5 cycles -> resp_valid and resp_data stable, and req_ready low throughout.
REQ-040 SHALL cover: rstn pulsed low mid-DATA -> uart_tx 1 and STATUS 0x4 after reset.
REQ-041 SHALL cover: with UART_TX_PARITY_EN, write 0x07 -> parity bit 1 and 11-bit frame.
